// File: rtl/vga_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_draw_arbiter
// Purpose  : Arbitrates N drawing engines onto the single VGA adapter pixel
//            write port. A client requests ownership, receives a registered
//            one-hot grant and streams pixels while it owns the port.
//            Fixed-priority or round-robin selection, optional burst limit.
// Ports    : clock     - system clock, rising edge
//            resetn    - asynchronous active-low reset
//            rr_mode   - 0 fixed priority (lowest index), 1 round-robin
//            req       - per-client ownership request
//            plot_in   - per-client pixel strobe
//            x_in/y_in/color_in - flattened per-client pixel data
//            grant     - registered one-hot ownership
//            busy      - any grant high
//            plot/X/Y/color - registered pixel write to the adapter
// Revision : 1.0 - initial release
// ============================================================================
module vga_draw_arbiter #(
    parameter int N_CLIENTS = 4,
    parameter int X_W       = 9,
    parameter int Y_W       = 8,
    parameter int COLOR_W   = 3,
    parameter int MAX_BURST = 0
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           rr_mode,
    input  logic [N_CLIENTS-1:0]           req,
    input  logic [N_CLIENTS-1:0]           plot_in,
    input  logic [N_CLIENTS*X_W-1:0]       x_in,
    input  logic [N_CLIENTS*Y_W-1:0]       y_in,
    input  logic [N_CLIENTS*COLOR_W-1:0]   color_in,
    output logic [N_CLIENTS-1:0]           grant,
    output logic                           busy,
    output logic                           plot,
    output logic [X_W-1:0]                 X,
    output logic [Y_W-1:0]                 Y,
    output logic [COLOR_W-1:0]             color
);

    localparam int OW = $clog2(N_CLIENTS);
    localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [BW-1:0]        c_BURST_MAX = BW'(MAX_BURST);
    localparam logic [OW-1:0]        c_LAST_IDX  = OW'(N_CLIENTS - 1);
    localparam logic [N_CLIENTS-1:0] c_ONE       = {{(N_CLIENTS-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [OW-1:0]          r_owner;
    logic [OW-1:0]          w_owner_nxt;
    logic [OW-1:0]          r_rr_ptr;
    logic [BW-1:0]          r_burst_cnt;
    logic [N_CLIENTS-1:0]   r_grant;
    logic                   r_plot;
    logic [X_W-1:0]         r_x;
    logic [Y_W-1:0]         r_y;
    logic [COLOR_W-1:0]     r_color;

    logic [OW-1:0]          w_win_fixed;
    logic [OW-1:0]          w_win_rr;
    logic [OW-1:0]          w_winner;
    logic                   w_found_fixed;
    logic                   w_found_rr;
    logic                   w_any_req;
    logic [N_CLIENTS-1:0]   w_owner_oh;
    logic                   w_accept;
    logic                   w_others;
    logic                   w_limit_hit;
    logic                   w_release;
    logic [X_W-1:0]         w_pix_x;
    logic [Y_W-1:0]         w_pix_y;
    logic [COLOR_W-1:0]     w_pix_c;

    assign w_any_req = |req;

    // Fixed priority: lowest requesting index wins.
    always_comb begin
        w_win_fixed   = '0;
        w_found_fixed = 1'b0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (!w_found_fixed && req[i]) begin
                w_win_fixed   = OW'(i);
                w_found_fixed = 1'b1;
            end
        end
    end

    // Round-robin: first requester strictly after the last owner, wrapping.
    always_comb begin
        int idx;
        w_win_rr   = '0;
        w_found_rr = 1'b0;
        for (int k = 1; k <= N_CLIENTS; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= N_CLIENTS) begin
                idx = idx - N_CLIENTS;
            end
            if (!w_found_rr && req[idx]) begin
                w_win_rr   = OW'(idx);
                w_found_rr = 1'b1;
            end
        end
    end

    assign w_winner   = rr_mode ? w_win_rr : w_win_fixed;
    assign w_owner_oh = c_ONE << r_owner;
    assign w_accept   = (r_state == S_OWN) && req[r_owner] && plot_in[r_owner];
    assign w_others   = |(req & ~w_owner_oh);

    // The limit only forces a handoff when somebody else is waiting; a lone
    // owner keeps the port however long it streams.
    generate
        if (MAX_BURST > 0) begin : g_limit
            localparam logic [BW-1:0] c_BURST_LAST = BW'(MAX_BURST - 1);
            assign w_limit_hit = w_accept && (r_burst_cnt == c_BURST_LAST) && w_others;
        end else begin : g_no_limit
            assign w_limit_hit = 1'b0;
        end
    endgenerate

    assign w_release = !req[r_owner] || w_limit_hit;

    always_comb begin
        w_pix_x = x_in[r_owner*X_W +: X_W];
        w_pix_y = y_in[r_owner*Y_W +: Y_W];
        w_pix_c = color_in[r_owner*COLOR_W +: COLOR_W];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_OWN;
                    w_owner_nxt = w_winner;
                end
            end
            S_OWN: begin
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_grant <= (w_state_nxt == S_OWN) ? (c_ONE << w_owner_nxt) : '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rr_ptr    <= c_LAST_IDX;
            r_burst_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_burst_cnt <= '0;
            if (w_any_req) begin
                r_rr_ptr <= w_winner;
            end
        end else if (w_accept && (r_burst_cnt != c_BURST_MAX)) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
        end
    end

    // Pixel path: an accepted strobe appears one cycle later; otherwise the
    // coordinates and colour hold so the adapter sees stable data.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_plot  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_color <= '0;
        end else begin
            r_plot <= w_accept;
            if (w_accept) begin
                r_x     <= w_pix_x;
                r_y     <= w_pix_y;
                r_color <= w_pix_c;
            end
        end
    end

    assign grant = r_grant;
    assign busy  = |r_grant;
    assign plot  = r_plot;
    assign X     = r_x;
    assign Y     = r_y;
    assign color = r_color;

endmodule
`default_nettype wire

// File: tb/tb_vga_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_draw_arbiter
// Purpose  : Directed self-checking bench for vga_draw_arbiter (4 clients,
//            burst limit 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_draw_arbiter;

    logic        clock;
    logic        resetn;
    logic        rr_mode;
    logic [3:0]  req;
    logic [3:0]  plot_in;
    logic [35:0] x_in;
    logic [31:0] y_in;
    logic [11:0] color_in;
    logic [3:0]  grant;
    logic        busy;
    logic        plot;
    logic [8:0]  X;
    logic [7:0]  Y;
    logic [2:0]  color;

    int n_pass;
    int n_total;

    vga_draw_arbiter #(
        .N_CLIENTS (4),
        .X_W       (9),
        .Y_W       (8),
        .COLOR_W   (3),
        .MAX_BURST (4)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .rr_mode  (rr_mode),
        .req      (req),
        .plot_in  (plot_in),
        .x_in     (x_in),
        .y_in     (y_in),
        .color_in (color_in),
        .grant    (grant),
        .busy     (busy),
        .plot     (plot),
        .X        (X),
        .Y        (Y),
        .color    (color)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_pix(input int i, input int xv, input int yv, input int cv);
        x_in[i*9 +: 9]     = xv[8:0];
        y_in[i*8 +: 8]     = yv[7:0];
        color_in[i*3 +: 3] = cv[2:0];
    endtask

    task automatic test_reset();
        resetn = 1'b0; rr_mode = 1'b0; req = 4'b0000; plot_in = 4'b0000;
        x_in = '0; y_in = '0; color_in = '0;
        tick(); tick();
        n_total++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", grant); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (plot !== 1'b0) $display("FAIL reset_plot: got %b want 0", plot); else n_pass++;
        n_total++; if ({X, Y, color} !== 20'd0) $display("FAIL reset_xyc: got %0d,%0d,%0d want 0,0,0", X, Y, color); else n_pass++;
        resetn = 1'b1; req = 4'b0001;
        tick();
        n_total++; if (grant !== 4'b0001) $display("FAIL reset_first_grant: got %b want 0001", grant); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL reset_first_busy: got %b want 1", busy); else n_pass++;
        req = 4'b0000;
        tick();
        n_total++; if (grant !== 4'b0000) $display("FAIL reset_release: got %b want 0000", grant); else n_pass++;
    endtask

    task automatic test_single();
        req = 4'b0100;
        tick();
        n_total++; if (grant !== 4'b0100) $display("FAIL single_grant: got %b want 0100", grant); else n_pass++;
        for (int p = 0; p < 3; p++) begin
            plot_in = 4'b0100;
            set_pix(2, 10 + p, 20, 5);
            tick();
            n_total++;
            if (plot !== 1'b1 || X !== 9'(10 + p) || Y !== 8'd20 || color !== 3'd5)
                $display("FAIL single_pix%0d: got plot=%b %0d,%0d,%0d want 1 %0d,20,5", p, plot, X, Y, color, 10 + p);
            else n_pass++;
        end
        plot_in = 4'b0000;
        tick();
        n_total++; if (plot !== 1'b0 || X !== 9'd12) $display("FAIL single_hold: got plot=%b X=%0d want 0 12", plot, X); else n_pass++;
        req = 4'b0000;
        tick();
        n_total++; if (grant !== 4'b0000) $display("FAIL single_release: got %b want 0000", grant); else n_pass++;
    endtask

    task automatic test_fixed();
        rr_mode = 1'b0; req = 4'b0101;
        tick();
        n_total++; if (grant !== 4'b0001) $display("FAIL fixed_first: got %b want 0001", grant); else n_pass++;
        req = 4'b0100;
        tick();
        n_total++; if (grant !== 4'b0000) $display("FAIL fixed_gap: got %b want 0000", grant); else n_pass++;
        tick();
        n_total++; if (grant !== 4'b0100) $display("FAIL fixed_second: got %b want 0100", grant); else n_pass++;
        req = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        resetn = 1'b0;
        tick();
        resetn = 1'b1; rr_mode = 1'b1; req = 4'b1111;
        tick();
        n_total++; if (grant !== 4'b0001) $display("FAIL rr_first: got %b want 0001", grant); else n_pass++;
        for (int o = 0; o < 4; o++) begin
            plot_in = 4'b0001 << o;
            set_pix(o, 30 + o, 40 + o, o);
            tick();
            n_total++;
            if (plot !== 1'b1 || X !== 9'(30 + o)) $display("FAIL rr_pix%0d: got plot=%b X=%0d want 1 %0d", o, plot, X, 30 + o);
            else n_pass++;
            plot_in = 4'b0000;
            req = 4'b1111 & ~(4'b0001 << o);
            tick();
            n_total++; if (grant !== 4'b0000) $display("FAIL rr_gap%0d: got %b want 0000", o, grant); else n_pass++;
            req = 4'b1111;
            tick();
            want = 4'b0001 << ((o + 1) % 4);
            n_total++; if (grant !== want) $display("FAIL rr_grant%0d: got %b want %b", o, grant, want); else n_pass++;
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_burst_limit();
        rr_mode = 1'b1; req = 4'b0010;
        tick();
        n_total++; if (grant !== 4'b0010) $display("FAIL burst_grant: got %b want 0010", grant); else n_pass++;
        for (int p = 0; p < 5; p++) begin
            req = (p >= 1) ? 4'b1010 : 4'b0010;
            plot_in = 4'b0010;
            set_pix(1, 100 + p, 50, 2);
            tick();
            n_total++;
            if (p < 3) begin
                if (grant !== 4'b0010 || plot !== 1'b1 || X !== 9'(100 + p))
                    $display("FAIL burst_p%0d: got grant=%b plot=%b X=%0d want 0010 1 %0d", p, grant, plot, X, 100 + p);
                else n_pass++;
            end else if (p == 3) begin
                if (grant !== 4'b0000 || plot !== 1'b1 || X !== 9'd103)
                    $display("FAIL burst_release: got grant=%b plot=%b X=%0d want 0000 1 103", grant, plot, X);
                else n_pass++;
            end else begin
                if (grant !== 4'b1000 || plot !== 1'b0 || X !== 9'd103)
                    $display("FAIL burst_handoff: got grant=%b plot=%b X=%0d want 1000 0 103", grant, plot, X);
                else n_pass++;
            end
        end
        req = 4'b0000; plot_in = 4'b0000;
        tick();
    endtask

    task automatic test_unlimited_alone();
        req = 4'b0010;
        tick();
        n_total++; if (grant !== 4'b0010) $display("FAIL alone_grant: got %b want 0010", grant); else n_pass++;
        for (int p = 0; p < 6; p++) begin
            plot_in = 4'b0010;
            set_pix(1, 200 + p, 60, 4);
            tick();
            n_total++;
            if (grant !== 4'b0010 || plot !== 1'b1 || X !== 9'(200 + p))
                $display("FAIL alone_p%0d: got grant=%b plot=%b X=%0d want 0010 1 %0d", p, grant, plot, X, 200 + p);
            else n_pass++;
        end
        req = 4'b0000; plot_in = 4'b0000;
        tick();
        n_total++; if (grant !== 4'b0000) $display("FAIL alone_release: got %b want 0000", grant); else n_pass++;
    endtask

    task automatic test_foreign_strobe();
        rr_mode = 1'b0; req = 4'b0001;
        tick();
        n_total++; if (grant !== 4'b0001) $display("FAIL foreign_grant: got %b want 0001", grant); else n_pass++;
        set_pix(0, 1, 2, 3);
        set_pix(2, 99, 99, 7);
        plot_in = 4'b0100;
        tick();
        n_total++;
        if (plot !== 1'b0 || X !== 9'd205 || Y !== 8'd60 || color !== 3'd4)
            $display("FAIL foreign_drop: got plot=%b %0d,%0d,%0d want 0 205,60,4", plot, X, Y, color);
        else n_pass++;
        plot_in = 4'b0001;
        tick();
        n_total++;
        if (plot !== 1'b1 || X !== 9'd1 || Y !== 8'd2 || color !== 3'd3)
            $display("FAIL foreign_owner_pix: got plot=%b %0d,%0d,%0d want 1 1,2,3", plot, X, Y, color);
        else n_pass++;
        plot_in = 4'b0000; req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        rr_mode = 1'b0; req = 4'b0001;
        tick();
        plot_in = 4'b0001;
        set_pix(0, 7, 8, 6);
        tick();
        n_total++; if (plot !== 1'b1 || X !== 9'd7) $display("FAIL mid_pix: got plot=%b X=%0d want 1 7", plot, X); else n_pass++;
        #2;
        resetn = 1'b0;
        #1;
        n_total++;
        if (grant !== 4'b0000 || busy !== 1'b0 || plot !== 1'b0 || {X, Y, color} !== 20'd0)
            $display("FAIL mid_async_reset: got grant=%b busy=%b plot=%b %0d,%0d,%0d want all 0", grant, busy, plot, X, Y, color);
        else n_pass++;
        tick();
        n_total++; if (plot !== 1'b0 || grant !== 4'b0000) $display("FAIL mid_held_reset: got plot=%b grant=%b want 0 0000", plot, grant); else n_pass++;
        resetn = 1'b1; plot_in = 4'b0000;
        tick();
        n_total++; if (grant !== 4'b0001) $display("FAIL mid_regrant: got %b want 0001", grant); else n_pass++;
        req = 4'b0000;
        tick();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_single();
        test_fixed();
        test_round_robin();
        test_burst_limit();
        test_unlimited_alone();
        test_foreign_strobe();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_draw_arbiter.md
# vga_draw_arbiter

Parametrised pixel-write arbiter that sits between N drawing engines (map redraw, sprite, overlays, text) and the single VGA adapter write port. Each client requests ownership of the port, receives a registered one-hot grant, and streams pixels (plot strobe plus X/Y/colour) while it owns the port. The block supports fixed-priority and round-robin arbitration and optional burst limiting, so that no engine can starve the others. It replaces hard-wired if/else plot/colour muxing at the game top level.

## Interface
- N_CLIENTS, 4: number of requesting draw engines (2..8).
- X_W, 9: X coordinate width.
- Y_W, 8: Y coordinate width.
- COLOR_W, 3: colour width.
- MAX_BURST, 0: maximum pixels per ownership when others are waiting; 0 = unlimited.

- clock  in  1  system clock; everything is rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- rr_mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- req  in  N_CLIENTS  per-client ownership request, held for the whole burst.
- plot_in  in  N_CLIENTS  per-client pixel strobe.
- x_in  in  N_CLIENTS*X_W  flattened X, client i at [i*X_W +: X_W].
- y_in  in  N_CLIENTS*Y_W  flattened Y.
- color_in  in  N_CLIENTS*COLOR_W  flattened colour.
- grant  out  N_CLIENTS  registered one-hot ownership.
- busy  out  1  high while any grant is high.
- plot  out  1  registered write strobe to the VGA adapter.
- X  out  X_W  registered X.
- Y  out  Y_W  registered Y.
- color  out  COLOR_W  registered colour.

## Operation
- States: IDLE, OWN. Register owner index, rr_ptr (last owner), burst_cnt (width clog2(MAX_BURST+1), minimum 1).
- IDLE: if any req is high, pick a winner. In fixed mode, pick the lowest index with req=1. In rr mode, pick the first index with req=1 searching from rr_ptr+1 upward with wrap modulo N_CLIENTS. Next cycle: state OWN, grant[winner]=1, rr_ptr=winner, burst_cnt=0. If no req is high, stay in IDLE with grant=0.
- rr_mode is sampled only in IDLE. Changing it mid-burst affects the next arbitration only.
- OWN: a pixel is accepted when grant[o] & req[o] & plot_in[o]. On acceptance, the next cycle drives plot=1 and X/Y/color = client o's inputs. Otherwise plot=0 and X/Y/color hold their last values.
- Strobes from non-granted clients are dropped; no buffering. A client must wait for grant before plotting.
- burst_cnt increments on every accepted pixel and saturates at MAX_BURST.
- Release, evaluated each OWN cycle:
  - req[o]=0, or
  - MAX_BURST≠0, this cycle's pixel is accepted, burst_cnt==MAX_BURST-1, and any other req is high.
  - On release, the next cycle is IDLE with grant=0.
- With no other requester, the burst limit is ignored and the owner keeps the port indefinitely.
- A pixel accepted in the release cycle is still output.
- Invariants: grant is one-hot or zero; busy = |grant.

## Timing
- Reset (asynchronous, immediate) sets: state IDLE, grant=0, busy=0, plot=0, X=0, Y=0, color=0, burst_cnt=0, rr_ptr=N_CLIENTS-1 (so client 0 is favoured first in rr mode).
- Reset mid-burst aborts the burst. No pixel appears after resetn falls.
- Request to grant: the request is seen in IDLE at cycle t, and grant rises at t+1.
- Pixel latency: plot_in at cycle t gives plot/X/Y/color at t+1. A one-pixel-per-cycle stream is sustained.
- Handoff gap: grant is low for exactly one cycle (the IDLE cycle) between consecutive owners. plot is 0 during the gap unless a pixel was accepted in the release cycle.
- A request that rises and falls entirely during another owner's burst is not served.

## Test plan
- Reset: resetn=0 mid-stream at any cycle -> all outputs 0 in the same cycle. After release with req=0001 at t, grant=0001 at t+1.
- Single client: req[2]=1, grant seen, then plot_in[2] for 3 cycles with (10,20,5),(11,20,5),(12,20,5) -> identical triples on X/Y/color with plot=1, one cycle later each.
- Fixed priority: rr_mode=0, req=0101 simultaneously -> grant=0001. Drop req[0] -> one idle cycle, then grant=0100.
- Round-robin: rr_mode=1, req=1111 held, each owner plots one pixel then drops and reasserts req -> grant order 0001,0010,0100,1000,0001.
- Burst limit: MAX_BURST=4, client 1 streams continuously, client 3 requests at pixel 2 -> exactly 4 pixels from client 1, then grant=0 for one cycle, then grant=1000. Repeat with client 3 absent -> client 1 keeps the port past 4 pixels.
- Foreign strobes: client 0 owns, client 2 pulses plot_in with (99,99,7) -> that pixel never appears on the outputs.
